// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the memory-stage access controller and its helpers:
//   - accessState_t : FSM state encoding (IDLE / BUSY / DONE)
//   - byte-enable constants and the lane-to-bit shift amount
//   - byteEnable()  : byte-lane enable pattern for a given access width/lane
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } accessState_t;

    localparam logic [3:0] BYTE_EN_WORD  = 4'b1111;
    localparam logic [3:0] BYTE_EN_BYTE0 = 4'b0001;

    // A byte lane index is turned into a bit offset by shifting left by 3 (x8)
    localparam int BYTE_LANE_SHIFT = 3;

    // Word accesses touch every lane; byte accesses touch only the addressed lane
    function automatic logic [3:0] byteEnable(input logic fullWord, input logic [1:0] lane);
        byteEnable = fullWord ? BYTE_EN_WORD : (BYTE_EN_BYTE0 << lane);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Purely combinational load-data formatter. Picks the addressed byte lane
// (little-endian) or passes the whole word, then sign/zero-extends to 32 bits.
// Also used by the WB-side forwarding path, so it carries no state.
// Ports:
//   rdata      in  32  raw word returned by the data memory
//   addrLow    in   2  byte offset within the word
//   fullWord   in   1  1 = word load, 0 = byte load
//   signedLoad in   1  byte load: 1 = sign-extend, 0 = zero-extend
//   result     out 32  extended load value
// ---------------------------------------------------------------------------
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLow,
    input  logic        fullWord,
    input  logic        signedLoad,
    output logic [31:0] result
);

    logic [4:0]  bitOffset;
    logic [31:0] shifted;
    logic [7:0]  laneByte;

    // Move the addressed lane down to bits [7:0] before extending it
    always_comb begin
        bitOffset = 5'(addrLow) << BYTE_LANE_SHIFT;
        shifted   = rdata >> bitOffset;
        laneByte  = shifted[7:0];
        if (fullWord) begin
            result = rdata;
        end else begin
            result = {{24{signedLoad & laneByte[7]}}, laneByte};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory-stage access controller sitting right after the EXE/MEM register.
// Issues a req/ack access to data memory, stalls the pipeline until the access
// finishes (or times out), and delivers the extended load result to MEM/WB.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   aluResultIn / regData2In    effective address / store data
//   memReadIn / memWriteIn      load / store in MEM stage (write wins)
//   loadFullWordIn              1 = word, 0 = byte access
//   loadSignedIn                byte load sign-extension select
//   memReqOut/memWeOut/memAddrOut/memWDataOut/memByteEnOut  memory request side
//   memRDataIn / memAckIn       memory response side
//   loadDataOut                 registered extended load result
//   stallOut                    freeze PC and pipeline registers
//   alignErrOut                 misaligned word access this cycle
//   busErrOut                   sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aluResultIn,
    input  logic [31:0] regData2In,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic        loadFullWordIn,
    input  logic        loadSignedIn,
    output logic        memReqOut,
    output logic        memWeOut,
    output logic [31:0] memAddrOut,
    output logic [31:0] memWDataOut,
    output logic [3:0]  memByteEnOut,
    input  logic [31:0] memRDataIn,
    input  logic        memAckIn,
    output logic [31:0] loadDataOut,
    output logic        stallOut,
    output logic        alignErrOut,
    output logic        busErrOut
);

    accessState_t         state;
    logic [CNT_WIDTH-1:0] waitCount;

    logic        isRead;
    logic        isAccess;
    logic        misaligned;
    logic        validAccess;
    logic        timedOut;
    logic        requesting;
    logic [31:0] extendedData;

    // Decode the access; a store overrides a simultaneous load
    always_comb begin
        isRead      = memReadIn & ~memWriteIn;
        isAccess    = memReadIn | memWriteIn;
        misaligned  = loadFullWordIn & (aluResultIn[1:0] != 2'b00);
        validAccess = isAccess & ~misaligned;
        alignErrOut = isAccess & misaligned;
        timedOut    = (waitCount == CNT_WIDTH'(TIMEOUT_CYCLES));
    end

    // Request and stall go up in the same IDLE cycle the access appears so a
    // zero-wait ack costs nothing extra; reset kills any pending request
    always_comb begin
        requesting = ((state == IDLE) & validAccess) | (state == BUSY);
        memReqOut  = ~reset & requesting;
        stallOut   = ~reset & requesting;
    end

    // The pipeline is frozen while busy, so the bus fields can come straight
    // from the EXE/MEM inputs without extra holding registers
    always_comb begin
        memWeOut     = memWriteIn;
        memAddrOut   = {aluResultIn[31:2], 2'b00};
        memByteEnOut = byteEnable(loadFullWordIn, aluResultIn[1:0]);
        memWDataOut  = loadFullWordIn ? regData2In : {4{regData2In[7:0]}};
    end

    load_extend loadExtend (
        .rdata      (memRDataIn),
        .addrLow    (aluResultIn[1:0]),
        .fullWord   (loadFullWordIn),
        .signedLoad (loadSignedIn),
        .result     (extendedData)
    );

    // Access FSM: IDLE issues, BUSY waits for ack or timeout, DONE releases
    // the pipeline for exactly one cycle so the instruction is not reissued
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            waitCount   <= '0;
            loadDataOut <= '0;
            busErrOut   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (validAccess) begin
                        if (memAckIn) begin
                            state <= DONE;
                            if (isRead) begin
                                loadDataOut <= extendedData;
                            end
                        end else begin
                            state     <= BUSY;
                            waitCount <= CNT_WIDTH'(1);
                        end
                    end
                end
                BUSY: begin
                    if (memAckIn) begin
                        state <= DONE;
                        if (isRead) begin
                            loadDataOut <= extendedData;
                        end
                    end else if (timedOut) begin
                        state     <= DONE;
                        busErrOut <= 1'b1;
                        if (isRead) begin
                            loadDataOut <= '0;
                        end
                    end else begin
                        waitCount <= waitCount + CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    waitCount <= '0;
                end
                default: begin
                    state     <= IDLE;
                    waitCount <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage access controller that sits directly downstream of the EXE/MEM pipeline register. It consumes the latched ALU result (address), store data and memory control bits. It runs a req/ack handshake to the data memory and stalls the pipeline until the access completes. It also delivers the width-extracted, sign/zero-extended load result to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 16, maximum wait cycles for memAck before the access is abandoned with a bus error
CNT_WIDTH, 5, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
aluResultIn  input  32  effective address from EXE/MEM
regData2In  input  32  store data from EXE/MEM
memReadIn  input  1  load in MEM stage
memWriteIn  input  1  store in MEM stage
loadFullWordIn  input  1  1 = word access, 0 = byte access (applies to loads and stores)
loadSignedIn  input  1  byte load: 1 = sign-extend, 0 = zero-extend
memReqOut  output  1  memory request
memWeOut  output  1  1 = write, 0 = read
memAddrOut  output  32  word-aligned address (addr[1:0] forced to 00)
memWDataOut  output  32  write data
memByteEnOut  output  4  byte lane enables
memRDataIn  input  32  read data, valid when memAck is high
memAckIn  input  1  access complete
loadDataOut  output  32  extended load result to MEM/WB
stallOut  output  1  1 = hold PC and all pipeline registers (write=0)
alignErrOut  output  1  misaligned word access detected this cycle
busErrOut  output  1  sticky timeout error flag

Behaviour:
- Access = memReadIn | memWriteIn. If both are high, the write wins.
- Byte lanes are little-endian: byte k = addr[1:0] occupies bits [8k+7:8k].
- Word access: byteEn = 1111 and wdata = regData2In.
- Byte store: byteEn = 0001 << addr[1:0]; wdata = regData2In[7:0] replicated into all four lanes.
- Misaligned word access (loadFullWordIn=1, addr[1:0]!=00):
  - alignErrOut=1 combinationally.
  - No request is issued and there is no stall.
  - loadDataOut is unchanged.
  - The state machine stays in IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a valid aligned access, assert memReqOut and stallOut combinationally in the same cycle.
    - memAckIn the same cycle -> DONE.
    - Otherwise -> BUSY, and the wait counter loads 1.
  - BUSY: memReqOut=1, stallOut=1, and address, data and enables are held from the inputs (the pipeline is frozen, so the inputs are stable).
    - memAckIn -> DONE.
    - Counter reaches TIMEOUT_CYCLES without memAckIn -> set busErrOut, go to DONE.
    - Otherwise increment the counter.
  - DONE: memReqOut=0, stallOut=0 for exactly one cycle so the pipeline advances, then -> IDLE unconditionally. The same instruction is never reissued.
- Load capture: on the cycle memAckIn=1 for a read, loadDataOut <= extended data.
  - Word: memRDataIn as-is.
  - Byte: lane addr[1:0], sign- or zero-extended per loadSignedIn.
  - On timeout, loadDataOut <= 0.
  - loadDataOut holds its value until the next load completes.
- Non-memory instructions: no request, no stall, zero added latency.
- Latency: minimum 2 cycles per memory op (zero-wait ack), plus 1 cycle per extra wait cycle.
- memAckIn is ignored in IDLE-without-access and in DONE.
- busErrOut is sticky and is cleared only by reset.
- Reset (synchronous, active-high, may arrive mid-access):
  - State -> IDLE, counter=0, loadDataOut=0, busErrOut=0.
  - memReqOut and stallOut are forced 0 while reset is high, so a pending access is abandoned.
  - A late memAckIn is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), byte-enable constants, BYTE_LANE_SHIFT.
- Sub-module load_extend (combinational): takes rdata, addr[1:0], fullWord and signed, and returns the 32-bit extended result. It is reused by the WB-side forwarding logic.

Test Plan:
1. Word load, addr 0x00000010, memAck one cycle after req, rdata 0xDEADBEEF -> stall high 2 cycles, memAddr 0x10, byteEn 1111, loadDataOut 0xDEADBEEF on 3rd cycle, stall low.
2. Signed byte load at 0x13, rdata 0x80112233, zero-wait ack -> byteEn n/a (read), loadDataOut 0xFFFFFF80. Repeat unsigned -> 0x00000080.
3. Byte store 0x000000A5 at 0x22 -> memWe=1, byteEn 0100, memWData 0xA5A5A5A5, memAddr 0x20, stall exactly 1 cycle with zero-wait ack.
4. Word load at 0x06 -> alignErrOut=1, memReqOut=0, stallOut=0, loadDataOut unchanged.
5. No ack for TIMEOUT_CYCLES=16 -> stall high 17 cycles, busErrOut=1 thereafter, loadDataOut 0, pipeline released via DONE.
6. Reset asserted in 3rd BUSY cycle, then memAck arrives -> req/stall 0 during reset, state IDLE, loadDataOut 0, late ack ignored.
